bsg_tdm_slot_scheduler: RTL and testbench



---
 rtl/bsg_tdm_pkg.sv | 14 +
 rtl/bsg_counter_clear_up_one_hot.sv | 37 +++
 rtl/bsg_tdm_slot_scheduler.sv | 85 ++++++++
 tb/tb_bsg_tdm_slot_scheduler.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bsg_tdm_pkg.sv
// Shared types and sizing helpers for the TDM slot scheduler.
package bsg_tdm_pkg;

  typedef enum logic [0:0] {
    eRUN  = 1'b0,
    eTURN = 1'b1
  } tdm_state_e;

  // Width of the per-slot cycle counter; never narrower than one bit.
  function automatic int tdm_cnt_width(input int slot_len);
    return (slot_len > 1) ? $clog2(slot_len) : 1;
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up_one_hot.sv
// One-hot rotating pointer: clear reloads the init bit, up rotates left with wrap.
module bsg_counter_clear_up_one_hot #(
  parameter int max_val_p  = 3,
  parameter int init_val_p = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [max_val_p:0] count_r_o
);

  localparam int width_lp = max_val_p + 1;
  localparam logic [width_lp-1:0] init_lp = width_lp'(1) << init_val_p;

  logic [width_lp-1:0] count_q, count_d;

  always_comb begin
    // NOTE: next-state gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clear_i)
      count_d = init_lp;
    else if (up_i)
      count_d = {count_q[width_lp-2:0], count_q[width_lp-1]};
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset_i)
      count_q <= init_lp;
    else
      count_q <= count_d;
  end

  assign count_r_o = count_q;

endmodule

// File: rtl/bsg_tdm_slot_scheduler.sv
// Rotating TDM scheduler sharing one valid/ready channel among els_p requesters.
module bsg_tdm_slot_scheduler
  import bsg_tdm_pkg::*;
#(
  parameter int els_p        = 8,
  parameter int slot_len_p   = 4,
  parameter int skip_idle_p  = 1,
  parameter int turnaround_p = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             resync_i,
  input  logic [els_p-1:0] reqs_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic [els_p-1:0] grants_o,
  output logic             v_o,
  output logic [els_p-1:0] slot_o,
  output logic             slot_end_o
);

  localparam int cnt_w_lp = tdm_cnt_width(slot_len_p);
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(slot_len_p - 1);
  localparam logic skip_lp = (skip_idle_p != 0);
  localparam tdm_state_e after_end_lp = (turnaround_p != 0) ? eTURN : eRUN;

  tdm_state_e          state_q, state_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                run, owner_req, accept, slot_end;

  bsg_counter_clear_up_one_hot #(
    .max_val_p (els_p - 1),
    .init_val_p(0)
  ) slot_ptr (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (resync_i),
    .up_i     (slot_end),
    .count_r_o(slot_o)
  );

  // A resync cycle behaves like a dead cycle: no grant, no slot end.
  assign run       = (state_q == eRUN) & ~resync_i;
  assign owner_req = |(slot_o & reqs_i);
  assign grants_o  = run ? (slot_o & reqs_i) : '0;
  assign v_o       = |grants_o;
  assign accept    = v_o & ready_i;
  assign slot_end  = run & ((cnt_q == last_cnt_lp)
                          | (accept & last_i)
                          | (skip_lp & ~owner_req));
  assign slot_end_o = slot_end;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (resync_i) begin
      state_d = eRUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        eRUN: begin
          if (slot_end) begin
            state_d = after_end_lp;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_w_lp'(1);
          end
        end
        eTURN:   state_d = eRUN;
        default: state_d = eRUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eRUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bsg_tdm_slot_scheduler.sv
// Scoreboard bench: three scheduler configurations driven by one stimulus stream.
module tb_bsg_tdm_slot_scheduler;

  localparam int N   = 4;
  localparam int LEN = 3;

  typedef struct packed {
    logic [N-1:0] g;
    logic         v;
    logic [N-1:0] s;
    logic         e;
  } obs_t;

  logic clk = 1'b0;
  logic reset, resync, last, ready;
  logic [N-1:0] reqs;

  logic [N-1:0] g_a, s_a, g_b, s_b, g_c, s_c;
  logic v_a, e_a, v_b, e_b, v_c, e_c;

  int vectors = 0;
  int miscompares = 0;
  int step_no = 0;

  obs_t sb_q[$];

  // Model state per configuration: a = skip/no-turn, b = strict TDM, c = skip+turnaround.
  int skip_cfg [3] = '{1, 0, 1};
  int turn_cfg [3] = '{0, 0, 1};
  int m_slot   [3] = '{0, 0, 0};
  int m_cnt    [3] = '{0, 0, 0};
  bit m_turn   [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  bsg_tdm_slot_scheduler #(.els_p(N), .slot_len_p(LEN), .skip_idle_p(1), .turnaround_p(0)) dut_a (
    .clk_i(clk), .reset_i(reset), .resync_i(resync), .reqs_i(reqs), .last_i(last),
    .ready_i(ready), .grants_o(g_a), .v_o(v_a), .slot_o(s_a), .slot_end_o(e_a));

  bsg_tdm_slot_scheduler #(.els_p(N), .slot_len_p(LEN), .skip_idle_p(0), .turnaround_p(0)) dut_b (
    .clk_i(clk), .reset_i(reset), .resync_i(resync), .reqs_i(reqs), .last_i(last),
    .ready_i(ready), .grants_o(g_b), .v_o(v_b), .slot_o(s_b), .slot_end_o(e_b));

  bsg_tdm_slot_scheduler #(.els_p(N), .slot_len_p(LEN), .skip_idle_p(1), .turnaround_p(1)) dut_c (
    .clk_i(clk), .reset_i(reset), .resync_i(resync), .reqs_i(reqs), .last_i(last),
    .ready_i(ready), .grants_o(g_c), .v_o(v_c), .slot_o(s_c), .slot_end_o(e_c));

  function automatic obs_t predict(input int k);
    obs_t o;
    bit run, own, acc;
    run  = !m_turn[k] && !resync;
    own  = reqs[m_slot[k]];
    o.s  = N'(1) << m_slot[k];
    o.v  = run && own;
    o.g  = o.v ? o.s : '0;
    acc  = o.v && ready;
    o.e  = run && ((m_cnt[k] == LEN - 1) || (acc && last) || (skip_cfg[k] != 0 && !own));
    return o;
  endfunction

  function automatic obs_t observe(input int k);
    obs_t o;
    case (k)
      0:       o = '{g: g_a, v: v_a, s: s_a, e: e_a};
      1:       o = '{g: g_b, v: v_b, s: s_b, e: e_b};
      default: o = '{g: g_c, v: v_c, s: s_c, e: e_c};
    endcase
    return o;
  endfunction

  task automatic model_advance(input int k, input bit ended);
    if (reset || resync) begin
      m_slot[k] = 0;
      m_cnt[k]  = 0;
      m_turn[k] = 1'b0;
    end else if (m_turn[k]) begin
      m_turn[k] = 1'b0;
    end else if (ended) begin
      m_slot[k] = (m_slot[k] + 1) % N;
      m_cnt[k]  = 0;
      m_turn[k] = (turn_cfg[k] != 0);
    end else begin
      m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  // One clock of stimulus: push predictions, compare at negedge, step the models.
  task automatic step(input logic rst, input logic rs, input logic [N-1:0] rq,
                      input logic lst, input logic rdy, input bit chk);
    obs_t exp_o, act_o;
    bit   ended [3];
    reset  = rst;
    resync = rs;
    reqs   = rq;
    last   = lst;
    ready  = rdy;
    for (int k = 0; k < 3; k++) begin
      exp_o    = predict(k);
      ended[k] = exp_o.e;
      if (chk) sb_q.push_back(exp_o);
    end
    @(negedge clk);
    if (chk) begin
      for (int k = 0; k < 3; k++) begin
        exp_o = sb_q.pop_front();
        act_o = observe(k);
        vectors++;
        assert (act_o === exp_o) else begin
          miscompares++;
          $error("FAIL dut%0d step%0d: got g=%b v=%b slot=%b end=%b, want g=%b v=%b slot=%b end=%b",
                 k, step_no, act_o.g, act_o.v, act_o.s, act_o.e,
                 exp_o.g, exp_o.v, exp_o.s, exp_o.e);
        end
      end
    end
    for (int k = 0; k < 3; k++) model_advance(k, ended[k]);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; resync = 1'b0; reqs = '0; last = 1'b0; ready = 1'b0;
    @(posedge clk);
    #1;
    // Reset: state before the first edge is unknown, so only the second cycle is checked.
    step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b1);

    // Full rotation with every requester busy.
    for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b1);

    // Only requester 2 busy: idle skips vs strict TDM.
    step(1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b1);

    // Early end on last beat of slot 0.
    step(1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0011, 1'b0, 1'b1, 1'b1);

    // Stalled owner keeps its grant for the whole slot.
    step(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1);

    // Resync in the middle of slot 2.
    step(1'b0, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b1);

    // Resync on a cycle that would otherwise end the slot.
    step(1'b0, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a slot.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b1);

    // Mixed traffic.
    for (int i = 0; i < 300; i++)
      step(($urandom % 97) == 0, ($urandom % 29) == 0, N'($urandom),
           ($urandom % 4) == 0, ($urandom % 4) != 0, 1'b1);

    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
